// File: rtl/cpu_trace_parser.sv
// Streaming parser/checker for CPU write-trace lines, one ASCII character per clock.
// Define CPU_TRACE_SEMANTIC_EN to add PC range/alignment, grf and address checks on accepted lines.
module cpu_trace_parser #(
  parameter int unsigned                 TIME_DIGITS = 4,
  parameter int unsigned                 GRF_DIGITS  = 4,
  parameter int unsigned                 HEX_DIGITS  = 8,
  parameter logic [4*HEX_DIGITS-1:0]     PC_MIN      = 'h0000_3000,
  parameter logic [4*HEX_DIGITS-1:0]     PC_MAX      = 'h0000_4ffc
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               char,
  output logic [1:0]               format_type,
  output logic                     line_valid,
  output logic [3:0]               error_code,
  output logic [4*TIME_DIGITS-1:0] time_val,
  output logic [4*HEX_DIGITS-1:0]  pc_val,
  output logic [4*HEX_DIGITS-1:0]  dest_val,
  output logic [4*HEX_DIGITS-1:0]  data_val
);

  localparam int unsigned TW   = 4 * TIME_DIGITS;
  localparam int unsigned HW   = 4 * HEX_DIGITS;
  localparam int unsigned MAXD = (TIME_DIGITS > GRF_DIGITS) ?
                                 ((TIME_DIGITS > HEX_DIGITS) ? TIME_DIGITS : HEX_DIGITS) :
                                 ((GRF_DIGITS > HEX_DIGITS) ? GRF_DIGITS : HEX_DIGITS);
  localparam int unsigned CW   = $clog2(MAXD + 1) + 1;

  localparam logic [CW-1:0] CNT_TIME   = CW'(TIME_DIGITS);
  localparam logic [CW-1:0] CNT_GRF    = CW'(GRF_DIGITS);
  localparam logic [CW-1:0] CNT_HEX    = CW'(HEX_DIGITS);
  localparam logic [CW-1:0] CNT_HEX_M1 = CW'(HEX_DIGITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_SP1, S_GRF, S_ADDR, S_SP2, S_EQ, S_SP3, S_HASH, S_DONE
  } state_t;

  typedef enum logic [3:0] {
    E_NONE = 4'd0, E_TIME = 4'd1, E_PC = 4'd2, E_COLON = 4'd3, E_DEST = 4'd4,
    E_ARROW = 4'd5, E_DATA = 4'd6, E_HASH = 4'd7,
    E_PC_SEM = 4'd8, E_GRF_SEM = 4'd9, E_ADDR_SEM = 4'd10
  } err_t;

  state_t          state, state_nx;
  err_t            err_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [TW-1:0]   time_acc, time_nx;
  logic [HW-1:0]   pc_acc, pc_nx, dest_acc, dest_nx, data_acc, data_nx;
  logic            is_mem, mem_nx, accept;
  logic            is_dec, is_hex, is_sync;
  logic [3:0]      nib;

  always_comb begin
    is_dec  = (char >= "0") && (char <= "9");
    is_hex  = is_dec || ((char >= "a") && (char <= "f"));
    nib     = is_dec ? char[3:0] : 4'(char - 8'h57);
    is_sync = (char == "^");
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    time_nx  = time_acc;
    pc_nx    = pc_acc;
    dest_nx  = dest_acc;
    data_nx  = data_acc;
    mem_nx   = is_mem;
    err_nx   = E_NONE;
    accept   = 1'b0;
    if (is_sync) begin
      state_nx = S_TIME;
      cnt_nx   = '0;
      time_nx  = '0;
      pc_nx    = '0;
      dest_nx  = '0;
      data_nx  = '0;
    end else begin
      case (state)
        S_TIME:
          if (is_dec && cnt < CNT_TIME) begin
            time_nx = time_acc * TW'(10) + TW'(nib);
            cnt_nx  = cnt + CW'(1);
          end else if (char == "@" && cnt != '0) begin
            state_nx = S_PC;
            cnt_nx   = '0;
          end else err_nx = E_TIME;
        S_PC:
          if (is_hex && cnt < CNT_HEX) begin
            pc_nx  = {pc_acc[HW-5:0], nib};
            cnt_nx = cnt + CW'(1);
          end else if (char == ":" && cnt == CNT_HEX) state_nx = S_SP1;
          else if (is_hex || cnt != CNT_HEX)           err_nx = E_PC;
          else                                         err_nx = E_COLON;
        S_SP1:
          if (char == "$")      begin state_nx = S_GRF;  mem_nx = 1'b0; cnt_nx = '0; end
          else if (char == "*") begin state_nx = S_ADDR; mem_nx = 1'b1; cnt_nx = '0; end
          else if (char != " ") err_nx = E_DEST;
        S_GRF:
          if (is_dec && cnt < CNT_GRF) begin
            dest_nx = dest_acc * HW'(10) + HW'(nib);
            cnt_nx  = cnt + CW'(1);
          end else if ((char == " " || char == "<") && cnt != '0)
            state_nx = (char == " ") ? S_SP2 : S_EQ;
          else err_nx = E_DEST;
        S_ADDR:
          if (is_hex && cnt < CNT_HEX) begin
            dest_nx = {dest_acc[HW-5:0], nib};
            cnt_nx  = cnt + CW'(1);
          end else if ((char == " " || char == "<") && cnt == CNT_HEX)
            state_nx = (char == " ") ? S_SP2 : S_EQ;
          else err_nx = E_DEST;
        S_SP2:
          if (char == "<")      state_nx = S_EQ;
          else if (char != " ") err_nx = E_ARROW;
        S_EQ:
          if (char == "=") begin state_nx = S_SP3; cnt_nx = '0; end
          else err_nx = E_ARROW;
        S_SP3:
          if (is_hex) begin
            data_nx = {data_acc[HW-5:0], nib};
            cnt_nx  = cnt + CW'(1);
            if (cnt == CNT_HEX_M1) state_nx = S_HASH;
          end else if (!(char == " " && cnt == '0)) err_nx = E_DATA;
        S_HASH:
          if (char == "#") begin state_nx = S_DONE; accept = 1'b1; end
          else if (is_hex) err_nx = E_DATA;
          else             err_nx = E_HASH;
        default: state_nx = S_IDLE;  // IDLE and DONE ignore everything but '^'
      endcase
    end
`ifdef CPU_TRACE_SEMANTIC_EN
    if (accept) begin
      if (pc_acc < PC_MIN || pc_acc > PC_MAX || pc_acc[1:0] != 2'b00) err_nx = E_PC_SEM;
      else if (!is_mem && dest_acc >= HW'(32))                         err_nx = E_GRF_SEM;
      else if (is_mem && dest_acc[1:0] != 2'b00)                       err_nx = E_ADDR_SEM;
      accept = (err_nx == E_NONE);
    end
`endif
    if (err_nx != E_NONE) state_nx = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      time_acc    <= '0;
      pc_acc      <= '0;
      dest_acc    <= '0;
      data_acc    <= '0;
      is_mem      <= 1'b0;
      format_type <= 2'b00;
      line_valid  <= 1'b0;
      error_code  <= 4'd0;
      time_val    <= '0;
      pc_val      <= '0;
      dest_val    <= '0;
      data_val    <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      time_acc    <= time_nx;
      pc_acc      <= pc_nx;
      dest_acc    <= dest_nx;
      data_acc    <= data_nx;
      is_mem      <= mem_nx;
      line_valid  <= accept;
      format_type <= !accept ? 2'b00 : (is_mem ? 2'b10 : 2'b01);
      if (accept) begin
        time_val <= time_acc;
        pc_val   <= pc_acc;
        dest_val <= dest_acc;
        data_val <= data_acc;
      end
      // Only the first failure of a line is kept; '^' starts a fresh line.
      if (is_sync)                                     error_code <= 4'd0;
      else if (err_nx != E_NONE && error_code == 4'd0) error_code <= err_nx;
    end
  end

endmodule

// File: tb/tb_cpu_trace_parser.sv
// Directed self-checking bench for cpu_trace_parser (default parameters).
// Expectations follow CPU_TRACE_SEMANTIC_EN when the bench is built with it defined.
module tb_cpu_trace_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic [1:0]  format_type;
  logic        line_valid;
  logic [3:0]  error_code;
  logic [15:0] time_val;
  logic [31:0] pc_val, dest_val, data_val;

  int checks   = 0;
  int failures = 0;
  logic saw_valid;

  cpu_trace_parser dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .format_type (format_type),
    .line_valid  (line_valid),
    .error_code  (error_code),
    .time_val    (time_val),
    .pc_val      (pc_val),
    .dest_val    (dest_val),
    .data_val    (data_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one character, let the edge sample it, then look at the outputs 1 ns later.
  task automatic send(input logic [7:0] c);
    char = c;
    @(posedge clk);
    #1;
    if (line_valid) saw_valid = 1'b1;
  endtask

  task automatic send_str(input string s);
    saw_valid = 1'b0;
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic check_line(input string tag, input logic [1:0] ft, input logic [63:0] t,
                            input logic [63:0] pc, input logic [63:0] dst, input logic [63:0] dat);
    check({tag, "_fmt"},   64'(format_type), 64'(ft));
    check({tag, "_valid"}, 64'(line_valid),  64'(1));
    check({tag, "_err"},   64'(error_code),  64'(0));
    check({tag, "_time"},  64'(time_val),    t);
    check({tag, "_pc"},    64'(pc_val),      pc);
    check({tag, "_dest"},  64'(dest_val),    dst);
    check({tag, "_data"},  64'(data_val),    dat);
  endtask

  string err_lines [11] = '{
    "^@00003000: $1 <= 00000001#",
    "^1@0000300A: $1 <= 00000001#",
    "^1@0000300: x",
    "^1@000030001: $1 <= 00000001#",
    "^1@00003000; $1 <= 00000001#",
    "^1@00003000: %1 <= 00000001#",
    "^1@00003000: $12345 <= 00000001#",
    "^1@00003000: $1 =",
    "^1@00003000: $1 < = 00000001#",
    "^1@00003000: $1 <= 0000 0001#",
    "^1@00003000: $1 <= 00000001 #"
  };
  int err_codes [11] = '{1, 2, 2, 2, 3, 4, 4, 5, 5, 6, 7};

  string sem_lines [3] = '{
    "^1@00005000: $1 <= 00000001#",
    "^1@00003000: $40 <= 00000001#",
    "^1@00003000: *00000011 <= 00000001#"
  };
  int sem_codes [3] = '{8, 9, 10};

  initial begin
    reset = 1'b1;
    char  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fmt",   64'(format_type), 64'(0));
    check("rst_valid", 64'(line_valid),  64'(0));
    check("rst_err",   64'(error_code),  64'(0));
    check("rst_time",  64'(time_val),    64'(0));
    check("rst_pc",    64'(pc_val),      64'(0));
    check("rst_dest",  64'(dest_val),    64'(0));
    check("rst_data",  64'(data_val),    64'(0));
    reset = 1'b0;

    // Register-write line, then the pulse must drop after one cycle while fields hold.
    send_str("^10@00003000: $5 <= 0000000a#");
    check_line("reg", 2'b01, 64'd10, 64'h3000, 64'd5, 64'ha);
    send(" ");
    check("reg_fmt_next",   64'(format_type), 64'(0));
    check("reg_valid_next", 64'(line_valid),  64'(0));
    check("reg_data_hold",  64'(data_val),    64'ha);

    // Memory-write line with extra spaces and '<' straight after the address.
    send_str("^7@00003004:   *00000010<=  12345678#");
    check_line("mem", 2'b10, 64'd7, 64'h3004, 64'h10, 64'h1234_5678);

    // Fifth time digit overflows the field; previous fields hold.
    send_str("^12345@00003000: $1 <= 00000001#");
    check("tovf_seen", 64'(saw_valid),   64'(0));
    check("tovf_err",  64'(error_code),  64'(1));
    check("tovf_fmt",  64'(format_type), 64'(0));
    check("tovf_hold", 64'(time_val),    64'd7);

    // '^' clears a latched error at once.
    send("^");
    check("sync_clr_err", 64'(error_code), 64'(0));

    // Mid-line resync.
    send_str("^1@0000");
    send_str("^2@00003000: $1 <= 00000001#");
    check_line("resync", 2'b01, 64'd2, 64'h3000, 64'd1, 64'd1);

    // Misaligned PC: rejected only by the semantic checks.
    send_str("^1@00003002: $1 <= 00000001#");
`ifdef CPU_TRACE_SEMANTIC_EN
    check("pc3002_seen", 64'(saw_valid),   64'(0));
    check("pc3002_err",  64'(error_code),  64'(8));
    check("pc3002_fmt",  64'(format_type), 64'(0));
`else
    check_line("pc3002", 2'b01, 64'd1, 64'h3002, 64'd1, 64'd1);
`endif

    // One syntax error per field; the first failure is the one kept.
    for (int i = 0; i < 11; i++) begin
      send_str(err_lines[i]);
      check($sformatf("syn%0d_err", i),  64'(error_code), 64'(err_codes[i]));
      check($sformatf("syn%0d_seen", i), 64'(saw_valid),  64'(0));
    end

    for (int i = 0; i < 3; i++) begin
      send_str(sem_lines[i]);
`ifdef CPU_TRACE_SEMANTIC_EN
      check($sformatf("sem%0d_err", i),  64'(error_code), 64'(sem_codes[i]));
      check($sformatf("sem%0d_seen", i), 64'(saw_valid),  64'(0));
`else
      check($sformatf("sem%0d_err", i),  64'(error_code), 64'(0));
      check($sformatf("sem%0d_seen", i), 64'(saw_valid),  64'(1));
`endif
    end

    // Reset mid-line discards the partial line; the tail alone must not be accepted.
    send_str("^1@00");
    reset = 1'b1;
    send("0");
    reset = 1'b0;
    send_str("003000: $1 <= 00000001#");
    check("rml_seen", 64'(saw_valid),   64'(0));
    check("rml_fmt",  64'(format_type), 64'(0));
    check("rml_err",  64'(error_code),  64'(0));
    check("rml_time", 64'(time_val),    64'(0));
    check("rml_pc",   64'(pc_val),      64'(0));
    check("rml_dest", 64'(dest_val),    64'(0));
    check("rml_data", 64'(data_val),    64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
